uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Round-robin controller that shares the single UART transmitter of `uart_top` (`dintx`/`newd`/`donetx`) among `N_REQ` byte producers. It accepts a byte from one requester at a time and drives the UART's `newd` load strobe, which the UART samples on its slow baud clock. It then waits for `donetx`, inserts an idle gap so the UART sees `newd` low, and moves on to the next requester. Sits between the system's message sources and `uart_top`.

## Interface
- `N_REQ`, 4, number of requesters (2..8).
- `CLK_FREQ`, 1000000, system clock in Hz.
- `BAUD`, 9600, UART baud rate.
- `GAP_CYCLES`, CLK_FREQ/BAUD, `newd`-low cycles after each frame (≥ one UART bit clock).
- `TIMEOUT_CYCLES`, 12*CLK_FREQ/BAUD, maximum cycles in SEND before abort.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  N_REQ  requester i has a byte; held until its `req_ready` pulse.
- `req_data`  in  8*N_REQ  byte of requester i in bits [8i+7:8i]; stable while valid.
- `req_ready`  out  N_REQ  one-cycle acceptance pulse, one-hot.
- `grant_id`  out  $clog2(N_REQ)  index of requester currently/last served.
- `busy`  out  1  high in SEND and GAP.
- `uart_dintx`  out  8  byte to UART `dintx`.
- `uart_newd`  out  1  to UART `newd`; level, held high for whole SEND.
- `uart_donetx`  in  1  from UART `donetx`.
- `done_pulse`  out  1  one cycle on frame completion.
- `timeout_err`  out  1  one cycle when SEND aborts on timeout.

## Operation
- Reset values: all outputs 0; state IDLE; RR pointer = N_REQ-1, so requester 0 has top priority; `donetx` edge register 0.
- IDLE: if any `req_valid`, grant the first valid index searching from pointer+1 with wrap. At the next edge:
  - latch `req_data[g]` into `uart_dintx`
  - `grant_id`=g, pointer=g
  - `req_ready[g]`=1 for exactly that one cycle
  - `uart_newd`=1, timeout counter cleared
  - go to SEND
- No valid: stay IDLE, outputs hold (`uart_newd`=0).
- SEND: `uart_newd`=1 and `uart_dintx` stable. Ignore `req_valid`. Detect `donetx` rising edge: registered previous sample, `uart_donetx & ~prev`. On edge: `done_pulse`=1 for one cycle, `uart_newd`=0, go to GAP. Counter reaching TIMEOUT_CYCLES-1 without an edge: `timeout_err`=1 for one cycle, `uart_newd`=0, go to GAP.
- GAP: `uart_newd`=0. Count GAP_CYCLES, then go to IDLE.
- Simultaneous donetx edge and timeout in the same cycle: done wins; no `timeout_err`.
- `donetx` edges in IDLE or GAP are ignored.
- Last-served requester has lowest priority in the next arbitration. A requester that drops `req_valid` before `req_ready` is a protocol violation; the arbiter does not need to handle it.
- `rst` mid-SEND drops `uart_newd` on the next edge. The in-flight UART frame is not tracked.

## Timing
- Arbitration latency: `req_valid` seen in IDLE at cycle T → `req_ready`/`uart_newd` high at T+1.
- Completion: `uart_donetx` rises at cycle D → `done_pulse` and `uart_newd`=0 at D+1.
- Back-to-back requests: next `uart_newd` rise ≥ GAP_CYCLES+1 cycles after the `done_pulse` cycle.
- `busy`=1 from the cycle `uart_newd` rises through the last GAP cycle.

## Structure
- Package `uart_ctrl_pkg`:
  - state enum {IDLE, SEND, GAP}
  - function computing the default bit-period constant CLK_FREQ/BAUD
- Sub-module `rr_arbiter`: combinational rotate-priority encoder (inputs: valid vector, pointer; outputs: grant index, any-valid). Reusable by the planned RX dispatcher.
- Counters sized $clog2(max(GAP_CYCLES, TIMEOUT_CYCLES)+1).

## Test plan
Bench drives `uart_top` #(1000000,9600) behind the arbiter; GAP=104, TIMEOUT=1250.
- Single request: `req_valid`=4'b0100, data 8'hA5 → `req_ready`=4'b0100 one cycle later, serialized bits on `tx` = A5 LSB-first, one `done_pulse`, `grant_id`=2.
- All four valid with bytes 11,22,33,44 → frames sent in order 0,1,2,3; each `req_ready` exactly once; ≥104 newd-low cycles between frames.
- Fairness: requester 0 re-asserts immediately after service while 3 waits → order 0,1,2,3,0, never 0 twice before 3.
- Timeout: replace UART with stub that never raises `donetx` → `timeout_err` pulse 1250 cycles after `uart_newd` rise, then IDLE after 104 cycles.
- Reset mid-SEND with valid=4'b1000: assert `rst` one cycle → all outputs 0 next edge; after release with valid=4'b1001, requester 0 is granted first.

Source files
------------

// File: rtl/uart_ctrl_pkg.sv
// Shared types and helpers for the UART transmit-side controllers.
// Holds the controller state set and the bit-period arithmetic used for default timings.
package uart_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } uart_state_e;

  // System clock cycles per UART bit, truncated like the UART's own divider.
  function automatic int bit_period(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side byte handshake shared by all producers feeding the UART arbiter.
// Producers use the master modport, the arbiter uses the slave modport.
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_ready;

  modport master (
    output req_valid,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_data,
    output req_ready
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority encoder: picks the first valid index after ptr, wrapping.
// Kept standalone so the RX dispatcher can reuse it.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [IDW-1:0]   ptr,
  output logic [IDW-1:0]   grant,
  output logic             any_valid
);

  int idx;

  // Scanning from the farthest offset down lets the nearest valid index win last.
  always_comb begin
    grant     = '0;
    any_valid = |valid;
    idx       = 0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end
      if (valid[idx]) begin
        grant = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin front end that shares one UART transmitter among N_REQ byte producers.
// Holds newd for a whole frame, waits for donetx, then enforces a newd-low gap.
module uart_tx_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int CLK_FREQ       = 1000000,
  parameter int BAUD           = 9600,
  parameter int GAP_CYCLES     = bit_period(CLK_FREQ, BAUD),
  parameter int TIMEOUT_CYCLES = 12 * CLK_FREQ / BAUD
) (
  input  logic                     clk,
  input  logic                     rst,
  uart_tx_arbiter_if.slave         req,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     busy,
  output logic [7:0]               uart_dintx,
  output logic                     uart_newd,
  input  logic                     uart_donetx,
  output logic                     done_pulse,
  output logic                     timeout_err
);

  localparam int IDW  = $clog2(N_REQ);
  localparam int CNTW = $clog2(max_int(GAP_CYCLES, TIMEOUT_CYCLES) + 1);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_SEND = SEND;
  localparam logic [1:0] ST_GAP  = GAP;

  logic [1:0]       state;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   arb_grant;
  logic             arb_any;
  logic             done_prev;
  logic             done_edge;
  logic [CNTW-1:0]  cnt;
  logic [N_REQ-1:0] ready_q;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_rr_arbiter (
    .valid     (req.req_valid),
    .ptr       (ptr),
    .grant     (arb_grant),
    .any_valid (arb_any)
  );

  // donetx comes from the slow UART domain, so only a fresh rising edge ends a frame.
  assign done_edge     = uart_donetx & ~done_prev;
  assign busy          = (state != ST_IDLE);
  assign req.req_ready = ready_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      ptr         <= IDW'(N_REQ - 1);
      done_prev   <= 1'b0;
      cnt         <= '0;
      ready_q     <= '0;
      grant_id    <= '0;
      uart_dintx  <= '0;
      uart_newd   <= 1'b0;
      done_pulse  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      done_prev   <= uart_donetx;
      ready_q     <= '0;
      done_pulse  <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (arb_any) begin
            uart_dintx <= req.req_data[8*arb_grant +: 8];
            grant_id   <= arb_grant;
            ptr        <= arb_grant;
            ready_q    <= N_REQ'(1) << arb_grant;
            uart_newd  <= 1'b1;
            cnt        <= '0;
            state      <= ST_SEND;
          end
        end
        // A completion edge takes precedence over a timeout landing in the same cycle.
        ST_SEND: begin
          if (done_edge) begin
            done_pulse <= 1'b1;
            uart_newd  <= 1'b0;
            cnt        <= '0;
            state      <= ST_GAP;
          end else if (cnt == CNTW'(TIMEOUT_CYCLES - 1)) begin
            timeout_err <= 1'b1;
            uart_newd   <= 1'b0;
            cnt         <= '0;
            state       <= ST_GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_GAP: begin
          if (cnt == CNTW'(GAP_CYCLES - 1)) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          uart_newd <= 1'b0;
          cnt       <= '0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
